// File: rtl/lsu_bank_mem_if.sv
// Bus bundle between the LSU store/address decoder and the byte-banked data memory.
// The decoder side is the master. It drives the four bank ports and the load request.
// The memory side is the slave. It returns the aligned and extended load result.
interface lsu_bank_mem_if #(
    parameter int DEPTH_W = 10
);

    logic [DEPTH_W-1:0] i_addr_even_1;
    logic [DEPTH_W-1:0] i_addr_even_2;
    logic [DEPTH_W-1:0] i_addr_odd_1;
    logic [DEPTH_W-1:0] i_addr_odd_2;

    logic [7:0]         i_data_even_1;
    logic [7:0]         i_data_even_2;
    logic [7:0]         i_data_odd_1;
    logic [7:0]         i_data_odd_2;

    logic               i_we_even_1;
    logic               i_we_even_2;
    logic               i_we_odd_1;
    logic               i_we_odd_2;

    logic               i_ld_req;
    logic               i_ld_odd;
    logic [2:0]         i_ld_type;

    logic [31:0]        o_ld_data;
    logic               o_ld_valid;
    logic               o_ld_err;

    modport master (
        output i_addr_even_1, i_addr_even_2, i_addr_odd_1, i_addr_odd_2,
        output i_data_even_1, i_data_even_2, i_data_odd_1, i_data_odd_2,
        output i_we_even_1, i_we_even_2, i_we_odd_1, i_we_odd_2,
        output i_ld_req, i_ld_odd, i_ld_type,
        input  o_ld_data, o_ld_valid, o_ld_err
    );

    modport slave (
        input  i_addr_even_1, i_addr_even_2, i_addr_odd_1, i_addr_odd_2,
        input  i_data_even_1, i_data_even_2, i_data_odd_1, i_data_odd_2,
        input  i_we_even_1, i_we_even_2, i_we_odd_1, i_we_odd_2,
        input  i_ld_req, i_ld_odd, i_ld_type,
        output o_ld_data, o_ld_valid, o_ld_err
    );

endinterface

// File: rtl/lsu_bank_mem.sv
// Byte-banked LSU data memory with two parity banks (even and odd).
// Each bank has two ports.
// Stores land on the clock edge. Loads read all four ports into stage R.
// Stage O realigns and extends the bytes, so a load result appears two edges after
// the request.
module lsu_bank_mem #(
    parameter int DEPTH_W = 10
) (
    input  logic                i_clk,
    input  logic                i_reset,
    lsu_bank_mem_if.slave       bus
);

    localparam int DEPTH = 1 << DEPTH_W;

    localparam logic [2:0] LD_LB  = 3'b000;
    localparam logic [2:0] LD_LH  = 3'b001;
    localparam logic [2:0] LD_LW  = 3'b010;
    localparam logic [2:0] LD_LBU = 3'b100;
    localparam logic [2:0] LD_LHU = 3'b101;

    logic [7:0]  mem_even_q [DEPTH];
    logic [7:0]  mem_odd_q  [DEPTH];

    logic [7:0]  rd_e1_q;
    logic [7:0]  rd_e2_q;
    logic [7:0]  rd_o1_q;
    logic [7:0]  rd_o2_q;

    logic        req_q;
    logic        odd_q;
    logic [2:0]  type_q;

    logic [31:0] ld_data_q;
    logic [31:0] ld_data_d;
    logic        ld_valid_q;
    logic        ld_valid_d;
    logic        ld_err_q;
    logic        ld_err_d;

    logic [7:0]  b0;
    logic [7:0]  b1;
    logic [7:0]  b2;
    logic [7:0]  b3;
    logic [31:0] ext_data;
    logic        ext_illegal;

    // Even array writes: port _2 is applied last so it wins a same-index collision.
    // Writes are held off while reset is asserted.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            if (bus.i_we_even_1) begin
                mem_even_q[bus.i_addr_even_1] <= bus.i_data_even_1;
            end
            if (bus.i_we_even_2) begin
                mem_even_q[bus.i_addr_even_2] <= bus.i_data_even_2;
            end
        end
    end

    // Odd array writes: same priority and reset gating as the even array.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            if (bus.i_we_odd_1) begin
                mem_odd_q[bus.i_addr_odd_1] <= bus.i_data_odd_1;
            end
            if (bus.i_we_odd_2) begin
                mem_odd_q[bus.i_addr_odd_2] <= bus.i_data_odd_2;
            end
        end
    end

    // Synchronous reads from all four ports.
    // A write to the same index on the same edge is not seen, so the old byte is returned.
    always_ff @(posedge i_clk) begin
        rd_e1_q <= mem_even_q[bus.i_addr_even_1];
        rd_e2_q <= mem_even_q[bus.i_addr_even_2];
        rd_o1_q <= mem_odd_q[bus.i_addr_odd_1];
        rd_o2_q <= mem_odd_q[bus.i_addr_odd_2];
    end

    // Stage R: capture the request alongside the read bytes.
    // Reset drops any request in flight.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            req_q  <= 1'b0;
            odd_q  <= 1'b0;
            type_q <= 3'b000;
        end else begin
            req_q  <= bus.i_ld_req;
            odd_q  <= bus.i_ld_odd;
            type_q <= bus.i_ld_type;
        end
    end

    // Byte realignment and extension of the stage-R bytes.
    // The odd-address form swaps the parity of each byte lane.
    always_comb begin
        b0          = rd_e1_q;
        b1          = rd_o1_q;
        b2          = rd_e2_q;
        b3          = rd_o2_q;
        ext_data    = 32'h0000_0000;
        ext_illegal = 1'b0;

        if (odd_q) begin
            b0 = rd_o1_q;
            b1 = rd_e1_q;
            b2 = rd_o2_q;
            b3 = rd_e2_q;
        end

        case (type_q)
            LD_LB:   ext_data = {{24{b0[7]}}, b0};
            LD_LBU:  ext_data = {24'h00_0000, b0};
            LD_LH:   ext_data = {{16{b1[7]}}, b1, b0};
            LD_LHU:  ext_data = {16'h0000, b1, b0};
            LD_LW:   ext_data = {b3, b2, b1, b0};
            default: begin
                ext_data    = 32'h0000_0000;
                ext_illegal = 1'b1;
            end
        endcase
    end

    // Output stage next state: the data register only updates when a request is retiring.
    always_comb begin
        ld_data_d  = ld_data_q;
        ld_valid_d = req_q;
        ld_err_d   = 1'b0;
        if (req_q) begin
            ld_data_d = ext_data;
            ld_err_d  = ext_illegal;
        end
    end

    // Output stage O registers, cleared asynchronously on reset.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            ld_data_q  <= 32'h0000_0000;
            ld_valid_q <= 1'b0;
            ld_err_q   <= 1'b0;
        end else begin
            ld_data_q  <= ld_data_d;
            ld_valid_q <= ld_valid_d;
            ld_err_q   <= ld_err_d;
        end
    end

    assign bus.o_ld_data  = ld_data_q;
    assign bus.o_ld_valid = ld_valid_q;
    assign bus.o_ld_err   = ld_err_q;

endmodule

// File: tb/tb_lsu_bank_mem.sv
// Scoreboard bench for lsu_bank_mem.
// The stimulus side keeps a plain byte-array image of both banks.
// For each load it queues the expected result.
// A separate monitor pops and compares whenever the memory raises o_ld_valid.
module tb_lsu_bank_mem;

    localparam int DW   = 10;
    localparam int AMAX = 32;

    typedef struct {
        logic [31:0] data;
        logic        err;
        string       name;
    } exp_t;

    logic clock;
    logic reset;

    logic [7:0] mEven [AMAX];
    logic [7:0] mOdd  [AMAX];

    exp_t expQ [$];

    int total;
    int bad;

    lsu_bank_mem_if #(.DEPTH_W(DW)) bus ();

    lsu_bank_mem #(.DEPTH_W(DW)) dut (
        .i_clk   (clock),
        .i_reset (reset),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, expv);
        end
    endtask

    // Load result from the spec's byte rules.
    // Integer arithmetic is used for the sign extension.
    function automatic exp_t modelLoad(input bit odd, input logic [2:0] typ,
                                       input int ae1, input int ae2, input int ao1, input int ao2,
                                       input string name);
        exp_t e;
        int   b [4];
        int   v;
        if (!odd) begin
            b[0] = mEven[ae1]; b[1] = mOdd[ao1]; b[2] = mEven[ae2]; b[3] = mOdd[ao2];
        end else begin
            b[0] = mOdd[ao1]; b[1] = mEven[ae1]; b[2] = mOdd[ao2]; b[3] = mEven[ae2];
        end
        e.name = name;
        e.err  = 1'b0;
        case (typ)
            3'b000: begin v = b[0]; if (v >= 128) v -= 256; e.data = v; end
            3'b100: e.data = b[0];
            3'b001: begin v = b[1] * 256 + b[0]; if (v >= 32768) v -= 65536; e.data = v; end
            3'b101: e.data = b[1] * 256 + b[0];
            3'b010: e.data = ((b[3] * 256 + b[2]) * 256 + b[1]) * 256 + b[0];
            default: begin e.data = 32'h0; e.err = 1'b1; end
        endcase
        return e;
    endfunction

    task automatic pushExp(input logic [31:0] d, input logic err, input string name);
        exp_t e;
        e.data = d;
        e.err  = err;
        e.name = name;
        expQ.push_back(e);
    endtask

    // Drive one cycle of decoder traffic.
    // Update the bank image as the memory will see it at the coming edge.
    task automatic applyStimulus(input logic [3:0] we,
                                 input int ae1, input int ae2, input int ao1, input int ao2,
                                 input logic [7:0] de1, input logic [7:0] de2,
                                 input logic [7:0] do1, input logic [7:0] do2,
                                 input bit ldReq, input bit ldOdd, input logic [2:0] typ,
                                 input bit useModel, input string name);
        @(negedge clock);
        bus.i_we_even_1   = we[0];
        bus.i_we_even_2   = we[1];
        bus.i_we_odd_1    = we[2];
        bus.i_we_odd_2    = we[3];
        bus.i_addr_even_1 = DW'(ae1);
        bus.i_addr_even_2 = DW'(ae2);
        bus.i_addr_odd_1  = DW'(ao1);
        bus.i_addr_odd_2  = DW'(ao2);
        bus.i_data_even_1 = de1;
        bus.i_data_even_2 = de2;
        bus.i_data_odd_1  = do1;
        bus.i_data_odd_2  = do2;
        bus.i_ld_req      = ldReq;
        bus.i_ld_odd      = ldOdd;
        bus.i_ld_type     = typ;
        if (ldReq && useModel) begin
            expQ.push_back(modelLoad(ldOdd, typ, ae1, ae2, ao1, ao2, name));
        end
        if (!reset) begin
            if (we[0]) mEven[ae1] = de1;
            if (we[1]) mEven[ae2] = de2;
            if (we[2]) mOdd[ao1]  = do1;
            if (we[3]) mOdd[ao2]  = do2;
        end
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(4'b0000, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 3'b000, 1'b0, "idle");
        end
    endtask

    // Monitor: compare every valid pulse against the queue head.
    // Between pulses, check that the data register holds and the error flag stays low.
    initial begin : monitor
        exp_t        e;
        logic [31:0] lastData;
        lastData = 32'h0;
        forever begin
            @(posedge clock);
            #1;
            if (reset) lastData = 32'h0;
            if (bus.o_ld_valid === 1'b1) begin
                if (expQ.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL unexpected_valid: got valid=1 data=0x%08h expected valid=0", bus.o_ld_data);
                end else begin
                    e = expQ.pop_front();
                    checkOutput({e.name, "_data"}, bus.o_ld_data, e.data);
                    checkOutput({e.name, "_err"}, {31'b0, bus.o_ld_err}, {31'b0, e.err});
                    lastData = e.data;
                end
            end else begin
                checkOutput("hold_data", bus.o_ld_data, lastData);
                checkOutput("idle_err", {31'b0, bus.o_ld_err}, 32'h0);
                checkOutput("idle_valid", {31'b0, bus.o_ld_valid}, 32'h0);
            end
        end
    end

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        bus.i_we_even_1 = 1'b0; bus.i_we_even_2 = 1'b0;
        bus.i_we_odd_1  = 1'b0; bus.i_we_odd_2  = 1'b0;
        bus.i_addr_even_1 = '0; bus.i_addr_even_2 = '0;
        bus.i_addr_odd_1  = '0; bus.i_addr_odd_2  = '0;
        bus.i_data_even_1 = '0; bus.i_data_even_2 = '0;
        bus.i_data_odd_1  = '0; bus.i_data_odd_2  = '0;
        bus.i_ld_req = 1'b0; bus.i_ld_odd = 1'b0; bus.i_ld_type = 3'b000;

        #2;
        checkOutput("reset_data", bus.o_ld_data, 32'h0);
        checkOutput("reset_valid", {31'b0, bus.o_ld_valid}, 32'h0);
        checkOutput("reset_err", {31'b0, bus.o_ld_err}, 32'h0);

        repeat (2) @(negedge clock);
        reset = 1'b0;

        // Fill every index that later traffic uses.
        for (int i = 0; i < AMAX; i++) begin
            applyStimulus(4'b0101, i, 0, i, 0, 8'($urandom), 8'h00, 8'($urandom), 8'h00,
                          1'b0, 1'b0, 3'b000, 1'b0, "init");
        end

        // Word round trip at an even address.
        applyStimulus(4'b1111, 5, 6, 5, 6, 8'hEF, 8'hAD, 8'hBE, 8'hDE, 1'b0, 1'b0, 3'b000, 1'b0, "wr");
        applyStimulus(4'b0000, 5, 6, 5, 6, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 3'b010, 1'b0, "word_rt");
        pushExp(32'hDEADBEEF, 1'b0, "word_rt");

        // Odd alignment with sign and zero extension.
        applyStimulus(4'b0101, 3, 0, 2, 0, 8'h7F, 8'h00, 8'h80, 8'h00, 1'b0, 1'b0, 3'b000, 1'b0, "wr");
        applyStimulus(4'b0000, 3, 0, 2, 0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1, 3'b001, 1'b0, "odd_lh");
        pushExp(32'h00007F80, 1'b0, "odd_lh");
        applyStimulus(4'b0000, 3, 0, 2, 0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1, 3'b000, 1'b0, "odd_lb");
        pushExp(32'hFFFFFF80, 1'b0, "odd_lb");
        applyStimulus(4'b0000, 3, 0, 2, 0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1, 3'b100, 1'b0, "odd_lbu");
        pushExp(32'h00000080, 1'b0, "odd_lbu");

        // Read-before-write on one index.
        applyStimulus(4'b0001, 4, 0, 0, 0, 8'h22, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 3'b000, 1'b0, "wr");
        applyStimulus(4'b0001, 4, 0, 0, 0, 8'h11, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 3'b100, 1'b0, "rbw_old");
        pushExp(32'h00000022, 1'b0, "rbw_old");
        applyStimulus(4'b0000, 4, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 3'b100, 1'b0, "rbw_new");
        pushExp(32'h00000011, 1'b0, "rbw_new");

        // Back-to-back word loads.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(4'b0000, $urandom_range(0, AMAX-1), $urandom_range(0, AMAX-1),
                          $urandom_range(0, AMAX-1), $urandom_range(0, AMAX-1),
                          8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 1'($urandom), 3'b010, 1'b1, "pipe_lw");
        end

        // Illegal load type.
        applyStimulus(4'b0000, 1, 2, 1, 2, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 3'b011, 1'b0, "illegal");
        pushExp(32'h00000000, 1'b1, "illegal");
        idleCycles(3);

        // Reset one cycle after a request.
        // The request must vanish, and a write attempted under reset must not land.
        applyStimulus(4'b0000, 5, 6, 5, 6, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 3'b010, 1'b0, "dropped");
        @(negedge clock);
        reset = 1'b1;
        bus.i_ld_req      = 1'b0;
        bus.i_we_even_1   = 1'b1;
        bus.i_addr_even_1 = DW'(5);
        bus.i_data_even_1 = 8'h55;
        repeat (2) @(negedge clock);
        checkOutput("midreset_data", bus.o_ld_data, 32'h0);
        checkOutput("midreset_valid", {31'b0, bus.o_ld_valid}, 32'h0);
        bus.i_we_even_1 = 1'b0;
        reset = 1'b0;
        applyStimulus(4'b0000, 5, 6, 5, 6, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 3'b010, 1'b0, "after_reset");
        pushExp(32'hDEADBEEF, 1'b0, "after_reset");

        // Randomized mixed traffic against the bank image.
        for (int i = 0; i < 400; i++) begin
            applyStimulus(4'($urandom), $urandom_range(0, AMAX-1), $urandom_range(0, AMAX-1),
                          $urandom_range(0, AMAX-1), $urandom_range(0, AMAX-1),
                          8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                          1'($urandom), 1'($urandom), 3'($urandom_range(0, 7)), 1'b1, "rand");
        end

        idleCycles(6);
        checkOutput("drain_pending", 32'(expQ.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
